// File: rtl/sha512_pkg.sv
// Shared SHA-512 types, constants and round/schedule functions.
// IV and KT are stored index-0-first so IV as a flat vector is H0 in the MSBs.
package sha512_pkg;

    localparam int ROUNDS = 80;
    localparam int WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [0:7][WORD_W-1:0] IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam logic [0:ROUNDS-1][WORD_W-1:0] KT = {
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha512_kt_rom.sv
// Combinational SHA-512 round-constant ROM; indices past the last round read zero.
module sha512_kt_rom
    import sha512_pkg::*;
(
    input  logic [6:0]  round,
    output logic [63:0] kt
);

    assign kt = (round < 7'(ROUNDS)) ? KT[round] : '0;

endmodule

// File: rtl/sha512_msg_schedule.sv
// 16-word sliding message-schedule window; wt is the word for the current round.
module sha512_msg_schedule
    import sha512_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [1023:0] blk,
    output logic [63:0] wt
);

    // w[0] sits in the MSBs, so the block loads directly with W0 first.
    logic [0:15][WORD_W-1:0] w;
    word_t w_next;

    assign w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    assign wt     = w[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= '0;
        end else if (load) begin
            w <= blk;
        end else if (shift) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
        end
    end

endmodule

// File: rtl/sha512_round_engine.sv
// SHA-512 compression core: one 1024-bit block per 83+ cycles, Kt supplied by an external ROM.
// Handshake in IDLE, 80 ROUND cycles, one FINAL add cycle, then DONE holds the digest.
module sha512_round_engine
    import sha512_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [1023:0] blk_data,
    input  logic         first,
    output logic [6:0]   round,
    input  logic [63:0]  kt,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [511:0] digest,
    output logic         busy
);

    state_t state, state_nx;
    logic [6:0] rnd;
    logic [0:7][WORD_W-1:0] v;      // a..h, a at index 0
    logic [0:7][WORD_W-1:0] hreg;
    logic [0:7][WORD_W-1:0] base;
    logic first_q;
    logic accept;
    word_t wt, t1, t2;

    assign accept = blk_valid && blk_ready;

    sha512_msg_schedule u_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (state == ROUND),
        .blk   (blk_data),
        .wt    (wt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ROUND;
            ROUND:   if (rnd == 7'(ROUNDS-1)) state_nx = FINAL;
            FINAL:   state_nx = DONE;
            DONE:    if (dig_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        blk_ready = rst_n && (state == IDLE);
        dig_valid = (state == DONE);
        busy      = (state != IDLE);
        round     = (state == ROUND || state == FINAL) ? rnd : 7'd0;
    end

    assign t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6]) + kt + wt;
    assign t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);

    // A first block chains from IV even though hreg still holds the previous digest.
    assign base   = first_q ? IV : hreg;
    assign digest = hreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rnd     <= '0;
            v       <= '0;
            hreg    <= IV;
            first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    v       <= first ? IV : hreg;
                    first_q <= first;
                    rnd     <= '0;
                end
                ROUND: begin
                    v <= {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
                    if (rnd != 7'(ROUNDS-1)) rnd <= rnd + 7'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) hreg[i] <= base[i] + v[i];
                end
                default: ;
            endcase
        end
    end

endmodule
